// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - CPU fetch handshake and program RAM bus bundle
//
// Purpose : groups the CPU-side fetch handshake and the byte-wide program RAM
//           port that instr_fetch sits between.
// Ports   : master - CPU + RAM side (drives request/ack/flush and RAM data)
//           slave  - instr_fetch side (drives instruction bytes and RAM control)
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] program_counter;
    logic              fetch_req;
    logic              flush;
    logic              instr_ack;
    logic [7:0]        op_code;
    logic [7:0]        arg1;
    logic [7:0]        arg2;
    logic              instr_valid;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic [7:0]        mem_rdata;

    modport master (
        output program_counter, fetch_req, flush, instr_ack, mem_rdata,
        input  op_code, arg1, arg2, instr_valid, busy, mem_addr, mem_en
    );

    modport slave (
        input  program_counter, fetch_req, flush, instr_ack, mem_rdata,
        output op_code, arg1, arg2, instr_valid, busy, mem_addr, mem_en
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch responder with one-entry hit buffer
//
// Purpose : reads op_code/arg1/arg2 (bytes pc, pc+1, pc+2) from a byte-wide
//           synchronous program RAM, one byte per cycle, and presents them to
//           the CPU with a valid/ack handshake. A one-entry buffer returns a
//           repeated pc in one cycle without touching the RAM.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - slave side of instr_fetch_if (CPU handshake + RAM port)
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int BUF_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_en_q, mem_en_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [7:0]        op_q, op_d;
    logic [7:0]        a1_q, a1_d;
    logic [7:0]        a2_q, a2_d;
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic [7:0]        buf_op_q, buf_op_d;
    logic [7:0]        buf_a1_q, buf_a1_d;
    logic [7:0]        buf_a2_q, buf_a2_d;

    logic hit;
    logic accept;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        mem_addr_d  = mem_addr_q;
        mem_en_d    = mem_en_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        op_d        = op_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_op_d    = buf_op_q;
        buf_a1_d    = buf_a1_q;
        buf_a2_d    = buf_a2_q;

        hit    = (BUF_EN != 0) && buf_valid_q && (bus.program_counter == buf_pc_q);
        // A new request is only looked at when nothing is pending for the CPU,
        // or on the edge where the CPU takes the pending instruction.
        accept = (state_q == S_IDLE) || ((state_q == S_VALID) && bus.instr_ack);

        if (bus.flush) begin
            // Data bytes deliberately keep their last value.
            state_d     = S_IDLE;
            valid_d     = 1'b0;
            mem_en_d    = 1'b0;
            busy_d      = 1'b0;
            buf_valid_d = 1'b0;
        end else if (state_q == S_FETCH) begin
            // RAM data lags the address by one edge, so each byte is captured
            // one step after its address was issued.
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0: mem_addr_d = pc_q + ADDR_W'(1);
                2'd1: begin
                    op_d       = bus.mem_rdata;
                    mem_addr_d = pc_q + ADDR_W'(2);
                end
                2'd2: begin
                    a1_d     = bus.mem_rdata;
                    mem_en_d = 1'b0;
                end
                default: begin
                    a2_d        = bus.mem_rdata;
                    valid_d     = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_VALID;
                    buf_valid_d = 1'b1;
                    buf_pc_d    = pc_q;
                    buf_op_d    = op_q;
                    buf_a1_d    = a1_q;
                    buf_a2_d    = bus.mem_rdata;
                end
            endcase
        end else if (accept) begin
            if (state_q == S_VALID) begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
            if (bus.fetch_req) begin
                if (hit) begin
                    op_d    = buf_op_q;
                    a1_d    = buf_a1_q;
                    a2_d    = buf_a2_q;
                    valid_d = 1'b1;
                    state_d = S_VALID;
                end else begin
                    pc_d       = bus.program_counter;
                    mem_addr_d = bus.program_counter;
                    mem_en_d   = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = 2'd0;
                    valid_d    = 1'b0;
                    state_d    = S_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            pc_q        <= '0;
            mem_addr_q  <= '0;
            mem_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            op_q        <= 8'h00;
            a1_q        <= 8'h00;
            a2_q        <= 8'h00;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_op_q    <= 8'h00;
            buf_a1_q    <= 8'h00;
            buf_a2_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            mem_addr_q  <= mem_addr_d;
            mem_en_q    <= mem_en_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            op_q        <= op_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_op_q    <= buf_op_d;
            buf_a1_q    <= buf_a1_d;
            buf_a2_q    <= buf_a2_d;
        end
    end

    assign bus.op_code     = op_q;
    assign bus.arg1        = a1_q;
    assign bus.arg2        = a2_q;
    assign bus.instr_valid = valid_q;
    assign bus.busy        = busy_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_en      = mem_en_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;
    logic clk;
    logic rst_n;

    instr_fetch_if #(.ADDR_W(8)) ifc ();

    instr_fetch #(.ADDR_W(8), .BUF_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [7:0]  addr_log [$];
    logic [23:0] sb [$];
    int          total = 0;
    int          bad   = 0;
    int          vseen = 0;

    // Synchronous program RAM model: data appears the edge after the address.
    always @(posedge clk) begin
        if (ifc.mem_en) ifc.mem_rdata <= mem[ifc.mem_addr];
        if (rst_n && ifc.mem_en) addr_log.push_back(ifc.mem_addr);
    end

    always @(negedge clk) if (ifc.instr_valid) vseen <= vseen + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_op"},    {24'd0, ifc.op_code}, 32'h0);
        chk({tag, "_arg1"},  {24'd0, ifc.arg1}, 32'h0);
        chk({tag, "_arg2"},  {24'd0, ifc.arg2}, 32'h0);
        chk({tag, "_valid"}, {31'd0, ifc.instr_valid}, 32'h0);
        chk({tag, "_busy"},  {31'd0, ifc.busy}, 32'h0);
        chk({tag, "_maddr"}, {24'd0, ifc.mem_addr}, 32'h0);
        chk({tag, "_men"},   {31'd0, ifc.mem_en}, 32'h0);
    endtask

    // Issue a request (optionally together with an ack of the pending
    // instruction) and check latency, RAM traffic and returned bytes.
    task automatic request(input string tag, input logic [7:0] pc, input bit with_ack, input bit hit);
        logic [7:0]  p1, p2;
        logic [23:0] e;
        int n;
        p1 = pc + 8'd1;
        p2 = pc + 8'd2;
        sb.push_back({mem[pc], mem[p1], mem[p2]});
        addr_log.delete();
        ifc.program_counter = pc;
        ifc.fetch_req       = 1'b1;
        ifc.instr_ack       = with_ack;
        tick();
        ifc.fetch_req       = 1'b0;
        ifc.instr_ack       = 1'b0;
        ifc.program_counter = ~pc;
        if (!hit) chk({tag, "_busy_e0"}, {31'd0, ifc.busy}, 32'h1);
        n = 0;
        while (!ifc.instr_valid && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, hit ? 32'd0 : 32'd4);
        chk({tag, "_busy_done"}, {31'd0, ifc.busy}, 32'h0);
        chk({tag, "_men_cycles"}, addr_log.size(), hit ? 32'd0 : 32'd3);
        if (!hit && addr_log.size() == 3) begin
            chk({tag, "_addr0"}, {24'd0, addr_log[0]}, {24'd0, pc});
            chk({tag, "_addr1"}, {24'd0, addr_log[1]}, {24'd0, p1});
            chk({tag, "_addr2"}, {24'd0, addr_log[2]}, {24'd0, p2});
        end
        e = sb.pop_front();
        chk({tag, "_bytes"}, {8'd0, ifc.op_code, ifc.arg1, ifc.arg2}, {8'd0, e});
    endtask

    task automatic ack(input string tag);
        ifc.instr_ack = 1'b1;
        tick();
        ifc.instr_ack = 1'b0;
        chk({tag, "_ack_clears"}, {31'd0, ifc.instr_valid}, 32'h0);
    endtask

    initial begin
        logic [23:0] held;
        int stable;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'hA7; mem[8'h11] = 8'h05; mem[8'h12] = 8'h03;
        mem[8'hFF] = 8'h10; mem[8'h00] = 8'h20; mem[8'h01] = 8'h30;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03;

        rst_n = 1'b0;
        ifc.program_counter = 8'h00;
        ifc.fetch_req = 1'b0;
        ifc.flush     = 1'b0;
        ifc.instr_ack = 1'b0;
        ifc.mem_rdata = 8'h00;
        tick();
        tick();
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Ack without a pending instruction is ignored.
        ifc.instr_ack = 1'b1;
        tick();
        ifc.instr_ack = 1'b0;
        chk("stray_ack_valid", {31'd0, ifc.instr_valid}, 32'h0);
        chk("stray_ack_busy",  {31'd0, ifc.busy}, 32'h0);

        request("t1_miss", 8'h10, 1'b0, 1'b0);
        ack("t1");
        request("t3_hit", 8'h10, 1'b0, 1'b1);
        ack("t3");
        request("t2_wrap", 8'hFF, 1'b0, 1'b0);
        ack("t2");

        // Flush sampled on E2 of a miss.
        vseen = 0;
        ifc.program_counter = 8'h10;
        ifc.fetch_req = 1'b1;
        tick();
        ifc.fetch_req = 1'b0;
        tick();
        ifc.flush = 1'b1;
        ifc.fetch_req = 1'b1;
        tick();
        ifc.flush = 1'b0;
        ifc.fetch_req = 1'b0;
        chk("t4_flush_valid", {31'd0, ifc.instr_valid}, 32'h0);
        chk("t4_flush_men",   {31'd0, ifc.mem_en}, 32'h0);
        chk("t4_flush_busy",  {31'd0, ifc.busy}, 32'h0);
        for (int i = 0; i < 6; i++) tick();
        chk("t4_no_valid", vseen, 32'd0);
        chk("t4_no_men",   {31'd0, ifc.mem_en}, 32'h0);
        request("t4_refetch", 8'h10, 1'b0, 1'b0);

        // Held instruction stays stable without ack.
        held   = {ifc.op_code, ifc.arg1, ifc.arg2};
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({ifc.op_code, ifc.arg1, ifc.arg2} !== held || ifc.instr_valid !== 1'b1) stable = 0;
        end
        chk("t5_hold_stable", stable, 32'd1);
        request("t5_ack_req", 8'h20, 1'b1, 1'b0);
        ack("t5");

        // Async reset in the middle of a miss, then buffer must be empty.
        ifc.program_counter = 8'h30;
        ifc.fetch_req = 1'b1;
        tick();
        ifc.fetch_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        request("t6_after_rst", 8'h20, 1'b0, 1'b0);
        ack("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
